// File: rtl/rsfq_cap_pkg.sv
// Shared types and default parameters for the RSFQ pulse capture block.
package rsfq_cap_pkg;

  typedef enum logic {
    CAP_IDLE  = 1'b0,
    CAP_ARMED = 1'b1
  } cap_state_e;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/rsfq_toggle_det.sv
// Synchronizes one toggle-encoded SFQ line and emits a single-cycle event per edge.
module rsfq_toggle_det
  import rsfq_cap_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tog_in,
  output logic event_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   event_q, event_d;

  // Event is registered so edge-to-event latency is SYNC_STAGES+1 cycles.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], tog_in};
    prev_d  = sync_q[SYNC_STAGES-1];
    event_d = sync_q[SYNC_STAGES-1] ^ prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      event_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      event_q <= event_d;
    end
  end

  assign event_o = event_q;

endmodule

// File: rtl/rsfq_pulse_capture.sv
// Frames toggle-encoded RSFQ gate output into words, one bit per RSFQ clock period.
// Optional double-pulse checker enabled by defining RSFQ_CAP_DBL_CHK_EN.
module rsfq_pulse_capture
  import rsfq_cap_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap_en,
  input  logic             sfq_clk_t,
  input  logic             sfq_q_t,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  input  logic             clr_flags,
  output logic             dbl_pulse,
  output logic [CNT_W-1:0] dbl_cnt
);

  localparam int                BIT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WIDTH - 1);

  logic clk_ev, q_ev;

  rsfq_toggle_det #(.SYNC_STAGES(SYNC_STAGES)) u_clk_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .tog_in  (sfq_clk_t),
    .event_o (clk_ev)
  );

  rsfq_toggle_det #(.SYNC_STAGES(SYNC_STAGES)) u_q_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .tog_in  (sfq_q_t),
    .event_o (q_ev)
  );

  cap_state_e       state_q, state_d;
  logic             flag_q, flag_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             period_bit;
  logic             word_done;
  logic [WIDTH-1:0] done_word;

  // A q event coincident with the closing clk event belongs to the closing period.
  always_comb begin
    state_d    = state_q;
    flag_d     = flag_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    word_done  = 1'b0;
    done_word  = '0;
    period_bit = flag_q | q_ev;

    if (!cap_en) begin
      state_d   = CAP_IDLE;
      flag_d    = 1'b0;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (clk_ev) begin
      flag_d = 1'b0;
      if (state_q == CAP_IDLE) begin
        state_d = CAP_ARMED;
      end else begin
        shift_d[bit_cnt_q] = period_bit;
        if (bit_cnt_q == LAST_BIT) begin
          word_done = 1'b1;
          done_word = shift_d;
          shift_d   = '0;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    end else if (q_ev) begin
      flag_d = 1'b1;
    end
  end

  // Single-entry output register; a completed word can replace one leaving in the same cycle.
  always_comb begin
    word_d     = word_q;
    valid_d    = valid_q;
    overflow_d = clr_flags ? 1'b0 : overflow_q;

    if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
    if (word_done) begin
      if (!valid_q || word_ready) begin
        word_d  = done_word;
        valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CAP_IDLE;
      flag_q     <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flag_q     <= flag_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign word_data  = word_q;
  assign word_valid = valid_q;
  assign overflow   = overflow_q;

`ifdef RSFQ_CAP_DBL_CHK_EN
  logic             dbl_seen_q, dbl_seen_d;
  logic             dbl_q, dbl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbl_hit;

  // dbl_seen limits the counter to one increment per affected period.
  always_comb begin
    dbl_hit    = cap_en & q_ev & flag_q;
    dbl_seen_d = dbl_seen_q;
    if (!cap_en || clk_ev) begin
      dbl_seen_d = 1'b0;
    end else if (dbl_hit) begin
      dbl_seen_d = 1'b1;
    end

    dbl_d = clr_flags ? 1'b0 : dbl_q;
    cnt_d = clr_flags ? '0 : cnt_q;
    if (dbl_hit) begin
      dbl_d = 1'b1;
      if (!dbl_seen_q && (cnt_d != '1)) begin
        cnt_d = cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbl_seen_q <= 1'b0;
      dbl_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      dbl_seen_q <= dbl_seen_d;
      dbl_q      <= dbl_d;
      cnt_q      <= cnt_d;
    end
  end

  assign dbl_pulse = dbl_q;
  assign dbl_cnt   = cnt_q;
`else
  assign dbl_pulse = 1'b0;
  assign dbl_cnt   = '0;
`endif

endmodule

// File: tb/tb_rsfq_pulse_capture.sv
// Scoreboard bench for rsfq_pulse_capture: randomized toggles checked against a period-level model.
module tb_rsfq_pulse_capture;

  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 8;

  logic             clk        = 1'b0;
  logic             rst_n      = 1'b0;
  logic             cap_en     = 1'b0;
  logic             sfq_clk_t  = 1'b0;
  logic             sfq_q_t    = 1'b0;
  logic             word_ready = 1'b1;
  logic             clr_flags  = 1'b0;
  logic [WIDTH-1:0] word_data;
  logic             word_valid;
  logic             overflow;
  logic             dbl_pulse;
  logic [CNT_W-1:0] dbl_cnt;

  always #5 clk = ~clk;

  rsfq_pulse_capture #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_en     (cap_en),
    .sfq_clk_t  (sfq_clk_t),
    .sfq_q_t    (sfq_q_t),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .clr_flags  (clr_flags),
    .dbl_pulse  (dbl_pulse),
    .dbl_cnt    (dbl_cnt)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_q[$];
  int mon_exp;

  // Reference model state, kept per RSFQ period rather than per clk cycle
  bit m_armed;
  int m_bits[$];
  int m_q_in_period;
  bit m_held;
  bit m_ovf;
  bit m_dbl;
  int m_dbl_cnt;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  function automatic void model_reset();
    m_armed       = 1'b0;
    m_bits.delete();
    m_q_in_period = 0;
    m_held        = 1'b0;
    m_ovf         = 1'b0;
    m_dbl         = 1'b0;
    m_dbl_cnt     = 0;
  endfunction

  function automatic void model_deliver(input int w);
    if (word_ready) begin
      exp_q.push_back(w);
    end else if (!m_held) begin
      m_held = 1'b1;
      exp_q.push_back(w);
    end else begin
      m_ovf = 1'b1;
    end
  endfunction

  function automatic void model_event(input bit ce, input bit qe);
    int w;
    if (!cap_en) return;
    if (qe) begin
      m_q_in_period++;
`ifdef RSFQ_CAP_DBL_CHK_EN
      if (m_q_in_period >= 2) m_dbl = 1'b1;
      if (m_q_in_period == 2 && m_dbl_cnt < (1 << CNT_W) - 1) m_dbl_cnt++;
`endif
    end
    if (ce) begin
      if (m_armed) begin
        m_bits.push_back((m_q_in_period > 0) ? 1 : 0);
        if (m_bits.size() == WIDTH) begin
          w = 0;
          for (int i = 0; i < WIDTH; i++) w = w | (m_bits[i] << i);
          m_bits.delete();
          model_deliver(w);
        end
      end else begin
        m_armed = 1'b1;
      end
      m_q_in_period = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit tc, input bit tq, input int gap);
    tick();
    if (tc) sfq_clk_t = ~sfq_clk_t;
    if (tq) sfq_q_t = ~sfq_q_t;
    model_event(tc, tq);
    repeat (gap) tick();
  endtask

  task automatic settle();
    repeat (SYNC_STAGES + 6) tick();
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    checkOutput({tag, "_dbl_pulse"}, 32'(dbl_pulse), 32'(m_dbl));
    checkOutput({tag, "_dbl_cnt"}, 32'(dbl_cnt), 32'(m_dbl_cnt));
  endtask

  task automatic clearFlags();
    settle();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    m_ovf     = 1'b0;
    m_dbl     = 1'b0;
    m_dbl_cnt = 0;
    tick();
    checkFlags("clr");
  endtask

  task automatic setCapEn(input bit v);
    settle();
    cap_en = v;
    if (!v) begin
      m_armed       = 1'b0;
      m_bits.delete();
      m_q_in_period = 0;
    end
    tick();
  endtask

  task automatic setReady(input bit v);
    settle();
    word_ready = v;
    if (v) m_held = 1'b0;
    settle();
  endtask

  // Monitor: every handshake pops one expected word
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_word: actual=%0h required=none", word_data);
        end else begin
          mon_exp = exp_q.pop_front();
          checkOutput("word_data", 32'(word_data), 32'(mon_exp));
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int r;
    bit tc, tq;

    // Reset with inputs toggling; lines end low so release creates no edge
    model_reset();
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      sfq_clk_t = ~sfq_clk_t;
      sfq_q_t   = ~sfq_q_t;
      tick();
      tick();
    end
    checkOutput("rst_word_valid", 32'(word_valid), 0);
    checkOutput("rst_word_data", 32'(word_data), 0);
    checkOutput("rst_overflow", 32'(overflow), 0);
    checkOutput("rst_dbl_pulse", 32'(dbl_pulse), 0);
    checkOutput("rst_dbl_cnt", 32'(dbl_cnt), 0);
    tick();
    rst_n      = 1'b1;
    cap_en     = 1'b1;
    word_ready = 1'b1;
    settle();

    // Pattern 8'h85: arm, then q in periods 0, 2 and 7
    applyStimulus(1, 0, 2);
    applyStimulus(0, 1, 2);
    applyStimulus(1, 0, 2);
    applyStimulus(1, 0, 2);
    applyStimulus(0, 1, 2);
    applyStimulus(1, 0, 2);
    applyStimulus(1, 0, 2);
    applyStimulus(1, 0, 2);
    applyStimulus(1, 0, 2);
    applyStimulus(1, 0, 2);
    applyStimulus(0, 1, 2);
    tick();
    sfq_clk_t = ~sfq_clk_t;
    model_event(1, 0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (word_valid) begin
        lat = k;
        break;
      end
    end
    checkOutput("valid_latency", 32'(lat), 32'(SYNC_STAGES + 3));
    settle();
    checkOutput("valid_after_handshake", 32'(word_valid), 0);
    checkOutput("pattern_queue_drained", 32'(exp_q.size()), 0);

    // Backpressure across two words
    setReady(0);
    for (int i = 0; i < 2 * WIDTH; i++) begin
      applyStimulus(1, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
    end
    settle();
    checkFlags("bp");
    checkOutput("bp_valid_held", 32'(word_valid), 1);
    checkOutput("bp_queue_len", 32'(exp_q.size()), 1);
    if (exp_q.size() > 0) checkOutput("bp_word_held", 32'(word_data), 32'(exp_q[0]));
    setReady(1);
    checkOutput("bp_queue_drained", 32'(exp_q.size()), 0);
    clearFlags();

    // Coincident q and clk edges credit the closing period
    for (int i = 0; i < WIDTH / 2; i++) begin
      applyStimulus(1, 1, 2);
      applyStimulus(1, 0, 2);
    end
    settle();
    checkOutput("coinc_queue_drained", 32'(exp_q.size()), 0);

    // Partial word discarded by cap_en low, then fresh arming
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 2);
    setCapEn(0);
    setCapEn(1);
    applyStimulus(1, 0, 2);
    for (int i = 0; i < WIDTH; i++) applyStimulus(1, 1'($urandom_range(0, 1)), 2);
    settle();
    checkOutput("capen_queue_drained", 32'(exp_q.size()), 0);

    // Two q pulses in one period
    applyStimulus(0, 1, 2);
    applyStimulus(0, 1, 2);
    applyStimulus(1, 0, 2);
    settle();
    checkFlags("dbl");
    for (int i = 0; i < WIDTH - 1; i++) applyStimulus(1, 0, 2);
    settle();
    checkOutput("dbl_queue_drained", 32'(exp_q.size()), 0);
    clearFlags();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        setCapEn(0);
        setCapEn(1);
      end else if (r < 6) begin
        settle();
        checkFlags("rand");
      end else if (r < 7) begin
        clearFlags();
      end else if (r < 9) begin
        setReady(0);
        for (int j = 0; j < 12; j++) applyStimulus(1, 1'($urandom_range(0, 1)), 1);
        settle();
        checkFlags("rand_bp");
        setReady(1);
      end else begin
        tc = 1'($urandom_range(0, 1));
        tq = 1'($urandom_range(0, 1));
        if (!tc && !tq) tc = 1'b1;
        applyStimulus(tc, tq, $urandom_range(1, 3));
      end
    end
    settle();
    settle();
    checkFlags("final");
    checkOutput("final_queue_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
